card_dealer: RTL and testbench
==============================

# card_dealer

Upstream card source for the Baccarat datapath. Runs a free-running 1..13 rank counter, captures its value into the next free hand slot on each deal request, and holds every dealt card as a stable 4-bit rank for the per-slot seven-segment decoders (rank 0 = empty slot, displayed blank). Slots 0–2 are the player hand and slots 3–5 the banker hand.

## Interface
Parameters:
- NUM_SLOTS, 6, number of card slots; legal range 1..8.

Ports:
- clk  input  1  system clock, rising edge.
- resetb  input  1  asynchronous active-low reset.
- deal_req  input  1  deal request level, synchronous to clk; rising edge detected internally.
- clear  input  1  synchronous one-cycle pulse; empties all slots.
- slots  output  4*NUM_SLOTS  slot i at bits [4i+3:4i]; 0 = empty, 1..13 = rank (A..K).
- slot_idx  output  4  index of the next slot to fill, 0..NUM_SLOTS.
- deal_ack  output  1  one-cycle pulse, cycle after a card is written.
- overflow  output  1  one-cycle pulse, cycle after a deal edge while full.
- full  output  1  high when slot_idx == NUM_SLOTS.
- pscore, dscore  output  4 each  present only with CARD_DEALER_SCORE_EN (see Configuration).

## Operation
- Rank counter rc: 4 bits, resets to 1, increments every clock, 13 -> 1 wrap. Never 0, never >13. Unaffected by clear.
- Edge detect: req_q is deal_req registered (reset 0). Deal edge = deal_req & ~req_q.
- States: EMPTY (slot_idx==0), PARTIAL (0<slot_idx<NUM_SLOTS), FULL (slot_idx==NUM_SLOTS).
  - EMPTY/PARTIAL + deal edge: slots[slot_idx] <= rc (pre-increment value), slot_idx++, deal_ack next cycle. Enters FULL when slot_idx reaches NUM_SLOTS.
  - FULL + deal edge: no write, slot_idx holds, overflow next cycle.
  - Any state + clear: all slots <= 0, slot_idx <= 0 -> EMPTY. No ack, no overflow.
- clear and deal edge in the same cycle: clear wins, the deal is dropped (not deferred). req_q still updates, so holding deal_req high after clear produces no deal.
- deal_req held high produces exactly one deal; the next one requires a low cycle.
- Reset values: slots all 0, slot_idx 0, full 0 (1 if NUM_SLOTS==0 is illegal, so 0), deal_ack 0, overflow 0, req_q 0, rc 1, pscore/dscore 0.
- Asynchronous reset asserted mid-operation clears everything immediately; no pending ack/overflow survives.

## Timing
- All outputs registered; no combinational input-to-output path.
- Deal edge sampled at rising edge n: slot, slot_idx and full update at edge n; deal_ack or overflow high for the cycle from edge n to edge n+1.
- rc value used at the n-th rising edge after reset release = ((n-1) mod 13)+1.
- Back-to-back deals need deal_req low for at least one sampled edge in between, so minimum deal spacing is 2 cycles.
- clear takes effect at the edge that samples it.

## Configuration
- CARD_DEALER_SCORE_EN defined: pscore and dscore ports exist. Card value = rank for 1..9, 0 for 10..13 and for empty slots. pscore = (value(slot0)+value(slot1)+value(slot2)) mod 10; dscore is the same over slots 3..5. Both registered, updating one cycle after any slot change, including clear. Requires NUM_SLOTS == 6; otherwise elaboration error.
- Undefined: score ports and logic absent; all other behaviour identical.

## Test plan
- Reset: resetb low then release; deal_req high first sampled at edge 5 -> slots[3:0]=5, slot_idx=1, deal_ack high the next cycle only, rc continues 6,7,...
- Wrap: deal sampled at edge 13 -> 13 (K). Deal sampled at edge 14 (after a low cycle between deals) -> 1. No deal ever captures 0 or a value above 13.
- Fill/overflow with NUM_SLOTS=6: six deals -> full=1, slot_idx=6; seventh deal edge -> slots unchanged, overflow pulses once, deal_ack stays low.
- Clear collision: clear and a deal edge at the same edge with slot_idx=2 -> all slots 0, slot_idx 0, no deal_ack; deal_req kept high afterwards produces no deal until it drops and rises again.
- Held request: deal_req high for 10 cycles -> exactly one deal_ack and slot_idx +1.
- Score (macro on): player ranks 5, 8, 13 -> pscore=3. Banker ranks 9, 9, 1 -> dscore=9. Clear -> both 0 one cycle later.

Source files
------------

// File: rtl/card_dealer.sv
// ---------------------------------------------------------------------------
// card_dealer
//
// Card source for the Baccarat datapath. A free-running rank counter cycles
// 1..13. On each rising edge of deal_req, the counter value is captured into
// the next free hand slot. Slots 0-2 hold the player hand and slots 3-5 hold
// the banker hand. Each slot is a stable 4-bit rank, where 0 means the slot
// is empty and is shown blank.
//
// Optional feature: when CARD_DEALER_SCORE_EN is defined, the block also
// registers Baccarat hand scores (pscore, dscore). That build requires
// NUM_SLOTS == 6.
//
// Ports:
//   clk       in   1            system clock, rising edge
//   resetb    in   1            asynchronous active-low reset
//   deal_req  in   1            deal request level; its rising edge deals
//   clear     in   1            synchronous pulse; empties all slots
//   slots     out  4*NUM_SLOTS  slot i at [4i+3:4i]; 0 = empty, 1..13 = rank
//   slot_idx  out  4            index of the next slot to fill, 0..NUM_SLOTS
//   deal_ack  out  1            pulse, the cycle after a card is written
//   overflow  out  1            pulse, the cycle after a deal edge while full
//   full      out  1            high when slot_idx == NUM_SLOTS
//   pscore    out  4            player score (CARD_DEALER_SCORE_EN only)
//   dscore    out  4            banker score (CARD_DEALER_SCORE_EN only)
// ---------------------------------------------------------------------------
module card_dealer #(
    parameter int NUM_SLOTS = 6
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   deal_req,
    input  logic                   clear,
    output logic [4*NUM_SLOTS-1:0] slots,
    output logic [3:0]             slot_idx,
    output logic                   deal_ack,
    output logic                   overflow,
    output logic                   full
`ifdef CARD_DEALER_SCORE_EN
    ,
    output logic [3:0]             pscore,
    output logic [3:0]             dscore
`endif
);

    localparam logic [3:0] NUM_W = 4'(NUM_SLOTS);

    generate
        if (NUM_SLOTS < 1 || NUM_SLOTS > 8) begin : g_bad_num_slots
            $error("card_dealer: NUM_SLOTS must be in 1..8");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [3:0]             idx_r;
    logic [3:0]             idx_s;
    logic [3:0]             rank_r;
    logic                   req_q_r;
    logic                   deal_edge_s;
    logic                   wr_en_s;
    logic                   clr_s;
    logic                   ack_s;
    logic                   ovf_s;
    logic                   ack_r;
    logic                   ovf_r;
    logic                   full_r;
    logic [4*NUM_SLOTS-1:0] slots_r;

    assign deal_edge_s = deal_req & ~req_q_r;

    // Free-running rank counter: 1..13. Any out-of-range value folds back to 1.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rank_r <= 4'd1;
        end else if (rank_r >= 4'd13) begin
            rank_r <= 4'd1;
        end else begin
            rank_r <= rank_r + 4'd1;
        end
    end

    // Delayed copy of deal_req for edge detection. It updates even when
    // clear is high, so a request held across a clear never deals.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            req_q_r <= 1'b0;
        end else begin
            req_q_r <= deal_req;
        end
    end

    // Next-state logic. A clear has priority and drops a simultaneous deal.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        wr_en_s = 1'b0;
        clr_s   = 1'b0;
        ack_s   = 1'b0;
        ovf_s   = 1'b0;
        if (clear) begin
            clr_s   = 1'b1;
            idx_s   = 4'd0;
            state_s = ST_EMPTY;
        end else if (deal_edge_s) begin
            case (state_r)
                ST_EMPTY, ST_PARTIAL: begin
                    wr_en_s = 1'b1;
                    ack_s   = 1'b1;
                    idx_s   = idx_r + 4'd1;
                    if ((idx_r + 4'd1) == NUM_W) begin
                        state_s = ST_FULL;
                    end else begin
                        state_s = ST_PARTIAL;
                    end
                end
                ST_FULL: begin
                    ovf_s = 1'b1;
                end
                default: begin
                    // Illegal encoding: recover to an empty hand.
                    clr_s   = 1'b1;
                    idx_s   = 4'd0;
                    state_s = ST_EMPTY;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, index and status-pulse registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_r <= ST_EMPTY;
            idx_r   <= 4'd0;
            full_r  <= 1'b0;
            ack_r   <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            full_r  <= (state_s == ST_FULL);
            ack_r   <= ack_s;
            ovf_r   <= ovf_s;
        end
    end

    // Slot storage: capture the pre-increment rank into the slot at idx_r.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            slots_r <= '0;
        end else if (clr_s) begin
            slots_r <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (wr_en_s && (idx_r == 4'(i))) begin
                    slots_r[4*i +: 4] <= rank_r;
                end
            end
        end
    end

    assign slots    = slots_r;
    assign slot_idx = idx_r;
    assign deal_ack = ack_r;
    assign overflow = ovf_r;
    assign full     = full_r;

`ifdef CARD_DEALER_SCORE_EN
    generate
        if (NUM_SLOTS != 6) begin : g_bad_score_cfg
            $error("card_dealer: CARD_DEALER_SCORE_EN requires NUM_SLOTS == 6");
        end
    endgenerate

    // Baccarat card value: ranks 1..9 count face value; tens, faces and
    // empty slots count 0.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        if (rank >= 4'd1 && rank <= 4'd9) begin
            card_value = rank;
        end else begin
            card_value = 4'd0;
        end
    endfunction

    // Sum of three card values mod 10. The raw sum is at most 27.
    function automatic logic [3:0] hand_score(input logic [3:0] a,
                                              input logic [3:0] b,
                                              input logic [3:0] c);
        logic [4:0] sum;
        sum = {1'b0, card_value(a)} + {1'b0, card_value(b)} + {1'b0, card_value(c)};
        if (sum >= 5'd20) begin
            sum = sum - 5'd20;
        end else if (sum >= 5'd10) begin
            sum = sum - 5'd10;
        end else begin
            sum = sum;
        end
        hand_score = sum[3:0];
    endfunction

    logic [3:0] pscore_r;
    logic [3:0] dscore_r;

    // Scores follow the registered slots, one cycle behind them.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            pscore_r <= 4'd0;
            dscore_r <= 4'd0;
        end else begin
            pscore_r <= hand_score(slots_r[3:0], slots_r[7:4], slots_r[11:8]);
            dscore_r <= hand_score(slots_r[15:12], slots_r[19:16], slots_r[23:20]);
        end
    end

    assign pscore = pscore_r;
    assign dscore = dscore_r;
`endif

endmodule

// File: tb/tb_card_dealer.sv
// ---------------------------------------------------------------------------
// tb_card_dealer
//
// Directed, table-driven bench for card_dealer with NUM_SLOTS = 6.
// After reset, the rank used at edge n is ((n-1) mod 13) + 1. Every expected
// slot value below comes from that relation.
// ---------------------------------------------------------------------------
module tb_card_dealer;

    logic        clk = 1'b0;
    logic        resetb;
    logic        deal_req;
    logic        clear;
    logic [23:0] slots;
    logic [3:0]  slot_idx;
    logic        deal_ack;
    logic        overflow;
    logic        full;
`ifdef CARD_DEALER_SCORE_EN
    logic [3:0]  pscore;
    logic [3:0]  dscore;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    card_dealer #(.NUM_SLOTS(6)) dut (
        .clk      (clk),
        .resetb   (resetb),
        .deal_req (deal_req),
        .clear    (clear),
        .slots    (slots),
        .slot_idx (slot_idx),
        .deal_ack (deal_ack),
        .overflow (overflow),
        .full     (full)
`ifdef CARD_DEALER_SCORE_EN
        ,
        .pscore   (pscore),
        .dscore   (dscore)
`endif
    );

    typedef struct {
        logic        ev;     // row has explicitly computed state
        logic        req;
        logic        clr;
        logic [23:0] slots;
        logic [3:0]  idx;
        logic        ack;
        logic        ovf;
        logic        full;
    } vec_t;

    vec_t vec [40];

    task automatic check(input string name, input int n, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, n, got, exp);
        end
    endtask

    task automatic set_ev(input int n, input logic req, input logic clr,
                          input logic [23:0] s, input logic [3:0] idx,
                          input logic ack, input logic ovf, input logic fl);
        vec[n] = '{1'b1, req, clr, s, idx, ack, ovf, fl};
    endtask

    task automatic tick(input logic req, input logic clr);
        deal_req = req;
        clear    = clr;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        resetb   = 1'b0;
        deal_req = 1'b0;
        clear    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_slots", 0, 32'(slots), 32'h0);
        check("rst_idx", 0, 32'(slot_idx), 32'h0);
        check("rst_ack", 0, 32'(deal_ack), 32'h0);
        check("rst_ovf", 0, 32'(overflow), 32'h0);
        check("rst_full", 0, 32'(full), 32'h0);
`ifdef CARD_DEALER_SCORE_EN
        check("rst_pscore", 0, 32'(pscore), 32'h0);
        check("rst_dscore", 0, 32'(dscore), 32'h0);
`endif
        resetb = 1'b1;
        cyc    = 0;
    endtask

    initial begin
        // ---- build the vector table (index = edge number after reset) ----
        for (int n = 0; n < 40; n++) begin
            vec[n] = '{1'b0, 1'b0, 1'b0, 24'h0, 4'd0, 1'b0, 1'b0, 1'b0};
        end
        set_ev(5,  1'b1, 1'b0, 24'h000005, 4'd1, 1'b1, 1'b0, 1'b0);
        vec[6].req  = 1'b1;                                          // held, no deal
        set_ev(8,  1'b1, 1'b0, 24'h000085, 4'd2, 1'b1, 1'b0, 1'b0);
        set_ev(10, 1'b1, 1'b1, 24'h000000, 4'd0, 1'b0, 1'b0, 1'b0);  // clear collision
        vec[11].req = 1'b1;                                          // held after clear
        set_ev(13, 1'b1, 1'b0, 24'h00000D, 4'd1, 1'b1, 1'b0, 1'b0);  // K
        set_ev(15, 1'b1, 1'b0, 24'h00002D, 4'd2, 1'b1, 1'b0, 1'b0);
        set_ev(17, 1'b1, 1'b0, 24'h00042D, 4'd3, 1'b1, 1'b0, 1'b0);
        set_ev(19, 1'b1, 1'b0, 24'h00642D, 4'd4, 1'b1, 1'b0, 1'b0);
        set_ev(21, 1'b1, 1'b0, 24'h08642D, 4'd5, 1'b1, 1'b0, 1'b0);
        set_ev(23, 1'b1, 1'b0, 24'hA8642D, 4'd6, 1'b1, 1'b0, 1'b1);  // full
        set_ev(25, 1'b1, 1'b0, 24'hA8642D, 4'd6, 1'b0, 1'b1, 1'b1);  // overflow
        set_ev(26, 1'b0, 1'b1, 24'h000000, 4'd0, 1'b0, 1'b0, 1'b0);  // clear
        set_ev(27, 1'b1, 1'b0, 24'h000001, 4'd1, 1'b1, 1'b0, 1'b0);  // wrap to A
        set_ev(29, 1'b1, 1'b0, 24'h000031, 4'd2, 1'b1, 1'b0, 1'b0);
        for (int n = 30; n <= 38; n++) vec[n].req = 1'b1;            // held 10 cycles
        // quiet rows keep the previous state, with no pulses
        for (int n = 1; n < 40; n++) begin
            if (!vec[n].ev) begin
                vec[n].slots = vec[n-1].slots;
                vec[n].idx   = vec[n-1].idx;
                vec[n].full  = vec[n-1].full;
            end
        end

        // ---- table run ----
        do_reset();
        for (int n = 1; n < 40; n++) begin
            tick(vec[n].req, vec[n].clr);
            check("slots", n, 32'(slots), 32'(vec[n].slots));
            check("slot_idx", n, 32'(slot_idx), 32'(vec[n].idx));
            check("deal_ack", n, 32'(deal_ack), 32'(vec[n].ack));
            check("overflow", n, 32'(overflow), 32'(vec[n].ovf));
            check("full", n, 32'(full), 32'(vec[n].full));
        end

        // ---- async reset while deal_ack is high (edge 40 rank = 1) ----
        tick(1'b1, 1'b0);
        check("pre_rst_ack", cyc, 32'(deal_ack), 32'h1);
        check("pre_rst_slots", cyc, 32'(slots), 32'h000131);
        #2 resetb = 1'b0;
        #1;
        check("async_ack", cyc, 32'(deal_ack), 32'h0);
        check("async_slots", cyc, 32'(slots), 32'h0);
        check("async_idx", cyc, 32'(slot_idx), 32'h0);

        // ---- score sequence: player 5,8,K; banker 9,9,A; then clear ----
        do_reset();
        for (int n = 1; n <= 43; n++) begin
            tick((n == 5) || (n == 8) || (n == 13) || (n == 22) || (n == 35) || (n == 40),
                 (n == 42));
`ifdef CARD_DEALER_SCORE_EN
            if (n == 8)  check("pscore_lat", n, 32'(pscore), 32'd5);
            if (n == 9)  check("pscore_58", n, 32'(pscore), 32'd3);
            if (n == 14) check("pscore_58K", n, 32'(pscore), 32'd3);
            if (n == 40) check("dscore_99", n, 32'(dscore), 32'd8);
            if (n == 41) check("dscore_991", n, 32'(dscore), 32'd9);
            if (n == 42) check("pscore_clr_lat", n, 32'(pscore), 32'd3);
            if (n == 43) check("pscore_clr", n, 32'(pscore), 32'd0);
            if (n == 43) check("dscore_clr", n, 32'(dscore), 32'd0);
`endif
            if (n == 41) check("score_seq_slots", n, 32'(slots), 32'h19_9D85);
            if (n == 42) check("clr_slots", n, 32'(slots), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
